sap1_control_sequencer: RTL and testbench
=========================================

Name: sap1_control_sequencer

Overview:
- Fetch/decode/execute controller for the SAP-1 extended datapath; it drives the 4-bit ALU function select and all register load/output-enable strobes.
- Sits between the instruction register and the datapath. The ALU computes from ALU_Sel; this block decides when and which ALU_Sel is issued and where the result is loaded.
- Variable-length instructions, 4 to 6 T-states, plus a sticky HALT state.

Parameters:
- T_MAX, 6, number of T-states in the longest instruction; the state encoding is sized from it.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  1 = start new fetches; 0 = hold in T1 after the current instruction
- instr  in  8  IR contents; [7:4] opcode, [3:0] address/operand
- zero_flag  in  1  accumulator == 0; sampled only during JZ T4
- pc_oe, pc_inc, pc_load  out  1 each  program counter strobes
- mar_load  out  1  memory address register load
- ram_oe  out  1  RAM drives bus
- ir_load, ir_oe  out  1 each  IR load; IR[3:0] drives bus
- a_load, a_oe, b_load  out  1 each  accumulator / B register strobes
- alu_oe  out  1  ALU_Out drives bus
- alu_sel  out  4  ALU function select
- out_load  out  1  output register load
- halted  out  1  HLT executed
- t_state  out  3  current T-state (1..6; 0 = HALT), for debug

Behaviour:
- Reset (async, any time, including mid-instruction):
  - state = T1, halted = 0, all strobes 0, alu_sel = 4'b0000.
  - The first fetch begins on the first rising edge after rst falls if run = 1.
- Strobes are decoded combinationally from the state register plus instr[7:4]. There is no output register; the datapath acts on them at the next rising edge.
- Fetch, common to all instructions:
  - T1: pc_oe, mar_load.
  - T2: pc_inc.
  - T3: ram_oe, ir_load.
- T1 with run = 0: no strobes, stay in T1. The run level is checked only in T1, so an instruction already started always completes.
- Opcode table (execute steps; the last listed step returns to T1):
  - 0000 NOP: T4 no strobes. 4 cycles.
  - 0001 LDA: T4 ir_oe+mar_load; T5 ram_oe+a_load. 5 cycles.
  - 0010 ADD / 0011 SUB / 0100 AND / 0101 OR / 0110 XOR: T4 ir_oe+mar_load; T5 ram_oe+b_load; T6 alu_oe+a_load. alu_sel = 0000 / 0001 / 0010 / 0011 / 0101 respectively. 6 cycles.
  - 0111 NOT: T4 alu_oe+a_load, alu_sel = 0110. 4 cycles.
  - 1000 INC: T4 alu_oe+a_load, alu_sel = 1001. 4 cycles.
  - 1001 JMP: T4 ir_oe+pc_load. 4 cycles.
  - 1010 JZ: T4 ir_oe+pc_load only if zero_flag = 1, otherwise no strobes. 4 cycles either way.
  - 1110 OUT: T4 a_oe+out_load. 4 cycles.
  - 1111 HLT: T4 no strobes, then move to HALT.
  - 1011, 1100, 1101 (undefined): executed as NOP.
- alu_sel is driven only while alu_oe = 1; otherwise it is 4'b0000.
- HALT state:
  - halted = 1, t_state = 0, all strobes 0.
  - Exit is by rst only. run is ignored.
- Invariant: at most one bus driver active per cycle. The bus drivers are pc_oe, ram_oe, ir_oe, a_oe, alu_oe.
- instr is ignored in T1–T3; it is sampled as an opcode only in T4–T6.

Decomposition:
- sap1_pkg holds:
  - opcode localparams (OP_NOP … OP_HLT);
  - ALU select constants (ALU_ADD = 0000, ALU_SUB = 0001, ALU_AND = 0010, ALU_OR = 0011, ALU_XOR = 0101, ALU_NOT = 1001? no: ALU_NOT = 0110, ALU_INC = 1001);
  - the T-state encoding (T1..T6, HALT).
- One sub-module, sap1_ctrl_decode: purely combinational, maps (state, opcode, zero_flag) to the control word.
- The top module holds the state register and the next-state logic.

Test Plan:
- rst pulse mid-T5 of LDA → asynchronous return: same cycle shows t_state = 1, all strobes 0, halted = 0. After release with run = 1, pc_oe = mar_load = 1.
- instr = 8'h2A (ADD 0xA), run = 1 → T1..T6 in exactly 6 cycles. T5 shows ram_oe+b_load; T6 shows alu_oe+a_load with alu_sel = 0000; next cycle is T1.
- instr = 8'h80 (INC) then 8'h70 (NOT) → each takes 4 cycles. T4 shows alu_sel = 1001, then 0110, each with alu_oe+a_load.
- instr = 8'hA5 (JZ) with zero_flag = 0, then with zero_flag = 1 → first T4 has no strobes; second T4 has ir_oe+pc_load. Both return to T1 after 4 cycles.
- run dropped to 0 during T3 of OUT (8'hE0) → T4 still issues a_oe+out_load; then the block holds in T1 with no strobes until run = 1.
- instr = 8'hF0 → after T4, halted = 1 and t_state = 0, steady for 20 cycles regardless of run. Asserting rst clears halted.
- All scenarios: an assertion checks that no more than one bus driver is asserted in any cycle.

Source files
------------

// File: rtl/sap1_pkg.sv
`default_nettype none
// =============================================================================
// Module      : sap1_pkg
// Description : Opcodes, ALU selects, T-state encoding and control word for the
//               SAP-1 extended control sequencer.
// Revision    : 1.0 - initial release
// =============================================================================
package sap1_pkg;

    localparam int T_MAX = 6;
    localparam int ST_W  = $clog2(T_MAX + 1);

    // Encoding doubles as the debug t_state value: T1..T6 = 1..6, HALT = 0.
    typedef enum logic [ST_W-1:0] {
        ST_HALT = 0,
        ST_T1   = 1,
        ST_T2   = 2,
        ST_T3   = 3,
        ST_T4   = 4,
        ST_T5   = 5,
        ST_T6   = 6
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_NOT = 4'b0110;
    localparam logic [3:0] ALU_INC = 4'b1001;

    typedef struct packed {
        logic       pc_oe;
        logic       pc_inc;
        logic       pc_load;
        logic       mar_load;
        logic       ram_oe;
        logic       ir_load;
        logic       ir_oe;
        logic       a_load;
        logic       a_oe;
        logic       b_load;
        logic       alu_oe;
        logic       out_load;
        logic [3:0] alu_sel;
    } ctrl_t;

    // Two-operand ALU instructions share the 6-cycle memory-operand sequence.
    function automatic logic is_alu2_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

    function automatic logic [3:0] alu2_sel(input logic [3:0] op);
        logic [3:0] sel;
        sel = ALU_ADD;
        case (op)
            OP_SUB:  sel = ALU_SUB;
            OP_AND:  sel = ALU_AND;
            OP_OR:   sel = ALU_OR;
            OP_XOR:  sel = ALU_XOR;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sap1_control_sequencer_if.sv
`default_nettype none
// =============================================================================
// Module      : sap1_control_sequencer_if
// Description : IR/flag inputs and datapath strobes of the SAP-1 sequencer.
// Revision    : 1.0 - initial release
// =============================================================================
interface sap1_control_sequencer_if;
    logic       run;
    logic [7:0] instr;
    logic       zero_flag;
    logic       pc_oe;
    logic       pc_inc;
    logic       pc_load;
    logic       mar_load;
    logic       ram_oe;
    logic       ir_load;
    logic       ir_oe;
    logic       a_load;
    logic       a_oe;
    logic       b_load;
    logic       alu_oe;
    logic [3:0] alu_sel;
    logic       out_load;
    logic       halted;
    logic [2:0] t_state;

    modport slave (
        input  run, instr, zero_flag,
        output pc_oe, pc_inc, pc_load, mar_load, ram_oe, ir_load, ir_oe,
               a_load, a_oe, b_load, alu_oe, alu_sel, out_load, halted, t_state
    );

    modport master (
        output run, instr, zero_flag,
        input  pc_oe, pc_inc, pc_load, mar_load, ram_oe, ir_load, ir_oe,
               a_load, a_oe, b_load, alu_oe, alu_sel, out_load, halted, t_state
    );
endinterface
`default_nettype wire

// File: rtl/sap1_ctrl_decode.sv
`default_nettype none
// =============================================================================
// Module      : sap1_ctrl_decode
// Description : Combinational map of (T-state, opcode, zero_flag, run) to the
//               control word plus end-of-instruction / halt indications.
// Revision    : 1.0 - initial release
// =============================================================================
module sap1_ctrl_decode
    import sap1_pkg::*;
(
    input  state_t     i_state,
    input  logic [3:0] i_opcode,
    input  logic       i_zero_flag,
    input  logic       i_run,
    output ctrl_t      o_ctrl,
    output logic       o_last,
    output logic       o_halt
);

    ctrl_t w_ctrl;
    logic  w_last;
    logic  w_halt;

    always_comb begin
        w_ctrl = '0;
        w_last = 1'b0;
        w_halt = 1'b0;
        case (i_state)
            ST_T1: begin
                w_ctrl.pc_oe    = i_run;
                w_ctrl.mar_load = i_run;
            end
            ST_T2: w_ctrl.pc_inc = 1'b1;
            ST_T3: begin
                w_ctrl.ram_oe  = 1'b1;
                w_ctrl.ir_load = 1'b1;
            end
            ST_T4: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        w_ctrl.ir_oe    = 1'b1;
                        w_ctrl.mar_load = 1'b1;
                    end
                    OP_NOT, OP_INC: begin
                        w_ctrl.alu_oe  = 1'b1;
                        w_ctrl.a_load  = 1'b1;
                        w_ctrl.alu_sel = (i_opcode == OP_NOT) ? ALU_NOT : ALU_INC;
                        w_last         = 1'b1;
                    end
                    OP_JMP, OP_JZ: begin
                        w_ctrl.ir_oe   = (i_opcode == OP_JMP) || i_zero_flag;
                        w_ctrl.pc_load = (i_opcode == OP_JMP) || i_zero_flag;
                        w_last         = 1'b1;
                    end
                    OP_OUT: begin
                        w_ctrl.a_oe     = 1'b1;
                        w_ctrl.out_load = 1'b1;
                        w_last          = 1'b1;
                    end
                    OP_HLT: begin
                        w_last = 1'b1;
                        w_halt = 1'b1;
                    end
                    default: w_last = 1'b1;
                endcase
            end
            ST_T5: begin
                if (i_opcode == OP_LDA) begin
                    w_ctrl.ram_oe = 1'b1;
                    w_ctrl.a_load = 1'b1;
                    w_last        = 1'b1;
                end else if (is_alu2_op(i_opcode)) begin
                    w_ctrl.ram_oe = 1'b1;
                    w_ctrl.b_load = 1'b1;
                end else begin
                    w_last = 1'b1;
                end
            end
            ST_T6: begin
                w_last = 1'b1;
                if (is_alu2_op(i_opcode)) begin
                    w_ctrl.alu_oe  = 1'b1;
                    w_ctrl.a_load  = 1'b1;
                    w_ctrl.alu_sel = alu2_sel(i_opcode);
                end
            end
            default: ;
        endcase
    end

    assign o_ctrl = w_ctrl;
    assign o_last = w_last;
    assign o_halt = w_halt;

endmodule
`default_nettype wire

// File: rtl/sap1_control_sequencer.sv
`default_nettype none
// =============================================================================
// Module      : sap1_control_sequencer
// Description : SAP-1 fetch/decode/execute controller: T-state register and
//               next-state logic around the combinational strobe decoder.
// Revision    : 1.0 - initial release
// =============================================================================
module sap1_control_sequencer
    import sap1_pkg::*;
#(
    parameter int T_MAX = sap1_pkg::T_MAX
) (
    input  logic                     clk,
    input  logic                     rst,
    sap1_control_sequencer_if.slave  bus
);

    localparam state_t c_last_state = state_t'(T_MAX);

    state_t     r_state;
    ctrl_t      w_ctrl;
    logic       w_last;
    logic       w_halt;
    logic       w_run;
    logic [3:0] w_opcode;

    // Reset is asynchronous, so the T1 fetch strobes are masked while it is held.
    assign w_run    = bus.run & ~rst;
    assign w_opcode = bus.instr[7:4];

    sap1_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_opcode    (w_opcode),
        .i_zero_flag (bus.zero_flag),
        .i_run       (w_run),
        .o_ctrl      (w_ctrl),
        .o_last      (w_last),
        .o_halt      (w_halt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_T1;
        end else begin
            case (r_state)
                ST_T1:   r_state <= bus.run ? ST_T2 : ST_T1;
                ST_T2:   r_state <= ST_T3;
                ST_T3:   r_state <= ST_T4;
                ST_T4, ST_T5, ST_T6: begin
                    if (w_halt)
                        r_state <= ST_HALT;
                    else if (w_last || r_state == c_last_state)
                        r_state <= ST_T1;
                    else
                        r_state <= state_t'(r_state + 1'b1);
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_T1;
            endcase
        end
    end

    assign bus.pc_oe    = w_ctrl.pc_oe;
    assign bus.pc_inc   = w_ctrl.pc_inc;
    assign bus.pc_load  = w_ctrl.pc_load;
    assign bus.mar_load = w_ctrl.mar_load;
    assign bus.ram_oe   = w_ctrl.ram_oe;
    assign bus.ir_load  = w_ctrl.ir_load;
    assign bus.ir_oe    = w_ctrl.ir_oe;
    assign bus.a_load   = w_ctrl.a_load;
    assign bus.a_oe     = w_ctrl.a_oe;
    assign bus.b_load   = w_ctrl.b_load;
    assign bus.alu_oe   = w_ctrl.alu_oe;
    assign bus.alu_sel  = w_ctrl.alu_sel;
    assign bus.out_load = w_ctrl.out_load;
    assign bus.halted   = (r_state == ST_HALT);
    assign bus.t_state  = 3'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_sap1_control_sequencer.sv
`default_nettype none
// =============================================================================
// Module      : tb_sap1_control_sequencer
// Description : Scoreboard bench for the SAP-1 control sequencer.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_sap1_control_sequencer;

    localparam logic [15:0] PC_OE    = 16'h8000;
    localparam logic [15:0] PC_INC   = 16'h4000;
    localparam logic [15:0] PC_LOAD  = 16'h2000;
    localparam logic [15:0] MAR_LOAD = 16'h1000;
    localparam logic [15:0] RAM_OE   = 16'h0800;
    localparam logic [15:0] IR_LOAD  = 16'h0400;
    localparam logic [15:0] IR_OE    = 16'h0200;
    localparam logic [15:0] A_LOAD   = 16'h0100;
    localparam logic [15:0] A_OE     = 16'h0080;
    localparam logic [15:0] B_LOAD   = 16'h0040;
    localparam logic [15:0] ALU_OE   = 16'h0020;
    localparam logic [15:0] OUT_LOAD = 16'h0010;

    typedef struct {
        string       name;
        logic [19:0] v;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];

    sap1_control_sequencer_if bus();

    sap1_control_sequencer #(.T_MAX(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] w_obs;
    assign w_obs = {bus.t_state, bus.halted, bus.pc_oe, bus.pc_inc, bus.pc_load,
                    bus.mar_load, bus.ram_oe, bus.ir_load, bus.ir_oe, bus.a_load,
                    bus.a_oe, bus.b_load, bus.alu_oe, bus.out_load, bus.alu_sel};

    function automatic logic [19:0] ev(input int t, input logic h, input logic [15:0] s);
        return {t[2:0], h, s};
    endfunction

    // Monitor: one expected control word per cycle, compared at the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (w_obs !== e.v) begin
                failures++;
                $display("FAIL %s: got t=%0d h=%0b strobes=%h, want t=%0d h=%0b strobes=%h",
                         e.name, w_obs[19:17], w_obs[16], w_obs[15:0],
                         e.v[19:17], e.v[16], e.v[15:0]);
            end
        end
    end

    always @(negedge clk) begin
        assert ($countones({bus.pc_oe, bus.ram_oe, bus.ir_oe, bus.a_oe, bus.alu_oe}) <= 1)
        else begin
            failures++;
            $display("FAIL bus_drivers: got %0d active drivers, want at most 1",
                     $countones({bus.pc_oe, bus.ram_oe, bus.ir_oe, bus.a_oe, bus.alu_oe}));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    task automatic step(input string name, input logic [19:0] v);
        sb.push_back('{name, v});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [7:0] ins);
        bus.instr = ins;
        step("fetch_t1", ev(1, 1'b0, PC_OE | MAR_LOAD));
        step("fetch_t2", ev(2, 1'b0, PC_INC));
        step("fetch_t3", ev(3, 1'b0, RAM_OE | IR_LOAD));
    endtask

    logic [7:0] alu_ins [5] = '{8'h2A, 8'h31, 8'h42, 8'h53, 8'h64};
    logic [3:0] alu_exp [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101};

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.run       = 1'b1;
        bus.instr     = 8'h00;
        bus.zero_flag = 1'b0;
        @(posedge clk);
        #1;
        step("reset_state", ev(1, 1'b0, 16'h0));
        rst = 1'b0;

        // LDA, interrupted by an asynchronous reset in the middle of T5
        fetch(8'h15);
        step("lda_t4", ev(4, 1'b0, IR_OE | MAR_LOAD));
        #2 rst = 1'b1;
        sb.push_back('{"async_reset_t5", ev(1, 1'b0, 16'h0)});
        @(posedge clk);
        #1;
        rst = 1'b0;

        fetch(8'h15);
        step("lda_t4", ev(4, 1'b0, IR_OE | MAR_LOAD));
        step("lda_t5", ev(5, 1'b0, RAM_OE | A_LOAD));

        for (int i = 0; i < 5; i++) begin
            fetch(alu_ins[i]);
            step("alu2_t4", ev(4, 1'b0, IR_OE | MAR_LOAD));
            step("alu2_t5", ev(5, 1'b0, RAM_OE | B_LOAD));
            step("alu2_t6", ev(6, 1'b0, ALU_OE | A_LOAD | {12'h0, alu_exp[i]}));
        end

        fetch(8'h80);
        step("inc_t4", ev(4, 1'b0, ALU_OE | A_LOAD | 16'h0009));
        fetch(8'h70);
        step("not_t4", ev(4, 1'b0, ALU_OE | A_LOAD | 16'h0006));

        bus.zero_flag = 1'b0;
        fetch(8'hA5);
        step("jz_not_taken_t4", ev(4, 1'b0, 16'h0));
        bus.zero_flag = 1'b1;
        fetch(8'hA5);
        step("jz_taken_t4", ev(4, 1'b0, IR_OE | PC_LOAD));
        bus.zero_flag = 1'b0;

        fetch(8'h93);
        step("jmp_t4", ev(4, 1'b0, IR_OE | PC_LOAD));
        fetch(8'h00);
        step("nop_t4", ev(4, 1'b0, 16'h0));
        fetch(8'hC7);
        step("undef_t4", ev(4, 1'b0, 16'h0));

        // OUT with run dropped during T3: the instruction still completes
        bus.instr = 8'hE0;
        step("out_t1", ev(1, 1'b0, PC_OE | MAR_LOAD));
        step("out_t2", ev(2, 1'b0, PC_INC));
        bus.run = 1'b0;
        step("out_t3", ev(3, 1'b0, RAM_OE | IR_LOAD));
        step("out_t4", ev(4, 1'b0, A_OE | OUT_LOAD));
        for (int i = 0; i < 3; i++)
            step("idle_t1", ev(1, 1'b0, 16'h0));
        bus.run = 1'b1;

        fetch(8'hF0);
        step("hlt_t4", ev(4, 1'b0, 16'h0));
        for (int i = 0; i < 20; i++) begin
            bus.run = i[0];
            step("halted", ev(0, 1'b1, 16'h0));
        end
        bus.run = 1'b1;
        #2 rst = 1'b1;
        sb.push_back('{"halt_reset", ev(1, 1'b0, 16'h0)});
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_halt_t1", ev(1, 1'b0, PC_OE | MAR_LOAD));

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
